// File: rtl/chan_pack16_pkg.sv
// Shared constants and state encoding for the 16-channel sample packer.
package chan_pack16_pkg;

    localparam int NCH = 16;
    localparam int W   = 16;
    localparam int CHW = 4;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/chan_pack16_sat_cnt.sv
// Generic saturating up-counter; holds at all-ones once reached.
module chan_pack16_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/chan_pack16.sv
// Packs channel-multiplexed samples into a 16-slot frame, checking channel order
// and zeroing masked slots at the moment the frame is published.
module chan_pack16
    import chan_pack16_pkg::CHW, chan_pack16_pkg::state_t,
           chan_pack16_pkg::ST_SYNC, chan_pack16_pkg::ST_FILL;
#(
    parameter int NCH  = 16,
    parameter int W    = 16,
    parameter int ERRW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W-1:0]       din,
    input  logic [CHW-1:0]     din_chan,
    input  logic               din_valid,
    input  logic [NCH-1:0]     chan_mask,
    output logic [NCH*W-1:0]   dout,
    output logic               dout_valid,
    output logic [15:0]        frame_cnt,
    output logic               err,
    output logic [ERRW-1:0]    err_cnt
);

    state_t         state_reg, state_next;
    logic [CHW-1:0] expected_reg, expected_next;
    logic           wr_en;
    logic           complete;
    logic           err_det;

    logic [W-1:0]     buf_reg [NCH];
    logic [NCH*W-1:0] frame_next;

    always_comb begin
        state_next    = state_reg;
        expected_next = expected_reg;
        wr_en         = 1'b0;
        complete      = 1'b0;
        err_det       = 1'b0;
        case (state_reg)
            ST_SYNC: begin
                if (din_valid && (din_chan == '0)) begin
                    wr_en         = 1'b1;
                    expected_next = CHW'(1);
                    state_next    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (din_valid) begin
                    if (din_chan == expected_reg) begin
                        wr_en = 1'b1;
                        if (expected_reg == CHW'(NCH - 1)) begin
                            complete      = 1'b1;
                            expected_next = '0;
                            state_next    = ST_SYNC;
                        end else begin
                            expected_next = expected_reg + 1'b1;
                        end
                    end else begin
                        err_det = 1'b1;
                        // A stray channel 0 is treated as the start of a fresh frame.
                        if (din_chan == '0) begin
                            wr_en         = 1'b1;
                            expected_next = CHW'(1);
                        end else begin
                            expected_next = '0;
                            state_next    = ST_SYNC;
                        end
                    end
                end
            end
            default: begin
                state_next    = ST_SYNC;
                expected_next = '0;
            end
        endcase
    end

    // Slot 15 bypasses the buffer so the frame can publish on the accepting edge.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
            logic [W-1:0] slot;
            assign slot = (gi == NCH - 1) ? din : buf_reg[gi];
            assign frame_next[gi*W +: W] = chan_mask[gi] ? '0 : slot;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_SYNC;
            expected_reg <= '0;
            for (int i = 0; i < NCH; i++) begin
                buf_reg[i] <= '0;
            end
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            expected_reg <= expected_next;
            if (wr_en) begin
                buf_reg[din_chan] <= din;
            end
            dout_valid <= complete;
            err        <= err_det;
            if (complete) begin
                dout      <= frame_next;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    chan_pack16_sat_cnt #(
        .WIDTH (ERRW)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (err_det),
        .count (err_cnt)
    );

endmodule
